// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: channel state encoding,
// default qualification time and small state helpers.
package btn_pkg;

  localparam int unsigned N_BTN_DEF           = 4;
  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;
  localparam int unsigned DEBOUNCE_CYCLES_MAX = (1 << 24) - 1;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] ch_state_t;

  localparam ch_state_t IDLE_LOW  = 2'd0;
  localparam ch_state_t WAIT_HIGH = 2'd1;
  localparam ch_state_t IDLE_HIGH = 2'd2;
  localparam ch_state_t WAIT_LOW  = 2'd3;

  // Debounced level is high while the accepted value is 1, including while a
  // falling edge is still being qualified.
  function automatic logic state_is_high(input ch_state_t s);
    return (s == IDLE_HIGH) || (s == WAIT_LOW);
  endfunction

  function automatic logic state_is_wait(input ch_state_t s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, qualification counter and FSM,
// registered level plus one-cycle press/release strobes.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic press_nxt_c
);

  localparam int unsigned CNT_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q,    sync_d;
  ch_state_t        state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  logic s2;
  logic cnt_done;

  assign s2       = sync_q[1];
  assign cnt_done = (cnt_q == CNT_LAST);

  // State register and all output/synchroniser flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state and counter; the counter only advances while it is below the
  // terminal value, so it can never wrap.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = IDLE_LOW;
        end else if (cnt_done) begin
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
        end else if (cnt_done) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs derived from the transition being taken
  always_comb begin
    level_d   = state_is_high(state_d);
    press_d   = 1'b0;
    release_d = 1'b0;
    if (state_is_wait(state_q) && cnt_done) begin
      press_d   = (state_q == WAIT_HIGH) &&  s2;
      release_d = (state_q == WAIT_LOW)  && !s2;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign press_nxt_c = press_d;

endmodule

// File: rtl/btn_debounce.sv
// Four-button conditioner for the pong game: independent debounced channels
// plus a registered any_press strobe aligned with btn_press.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_nxt;
  logic             any_press_q, any_press_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[g]),
      .btn_level   (btn_level[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g]),
      .press_nxt_c (press_nxt[g])
    );
  end

  // Built from next-cycle press values so it lands with btn_press
  always_comb begin
    any_press_d = |press_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule
